uart_rx_deframer: RTL and testbench

//  Receives serial packets on the chip's rx pin and delivers them to comms_ctrl.

---
 rtl/larpix_uart_pkg.sv | 11 +
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx_deframer.sv | 110 +++++++++++
 tb/tb_uart_rx_deframer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/larpix_uart_pkg.sv
// larpix_uart_pkg: shared UART framing types, bit constants and parity helper
package larpix_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam int PARITY_MAX_W = 256;
  // Callers zero-extend narrower words; padding zeros do not change parity.
  function automatic logic odd_parity_ok(input logic [PARITY_MAX_W-1:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for rx_in, optional 3-sample majority filter
// when UART_RX_GLITCH_FILTER_EN is defined.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic rx_in,
  output logic rxs
);
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= 2'b11;
    else sync_q <= {sync_q[0], rx_in};
`ifdef UART_RX_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) hist_q <= 2'b11;
    else hist_q <= {hist_q[0], sync_q[1]};
  // A lone low sample can never win the vote, so 1-clk glitches vanish.
  assign rxs = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign rxs = sync_q[1];
`endif
endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: oversampled UART receiver with odd-parity and stop-bit checks.
// Optional input majority filter: define UART_RX_GLITCH_FILTER_EN.
module uart_rx_deframer
  import larpix_uart_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int OVERSAMPLE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx_in,
  output logic [WIDTH-2:0] rx_data,
  output logic             rx_data_flag,
  output logic             parity_error,
  output logic             frame_error,
  output logic             rx_busy
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [SW-1:0] SAMP_MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_END = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic rxs, rxs_prev_q;
  rx_state_t state_q, state_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-2:0] data_q, data_d;
  logic flag_q, flag_d, perr_q, perr_d, ferr_q, ferr_d;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .rx_in   (rx_in),
    .rxs     (rxs)
  );

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    flag_d  = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: if (rxs_prev_q && rxs == START_BIT) begin
        state_d = START;
        samp_d  = '0;
      end
      START: if (samp_q == SAMP_MID) begin
        state_d = (rxs == START_BIT) ? DATA : IDLE;
        samp_d  = '0;
        bit_d   = '0;
      end
      DATA: if (samp_q == SAMP_END) begin
        shreg_d = {rxs, shreg_q[WIDTH-1:1]};
        bit_d   = bit_q + 1'b1;
        state_d = (bit_q == BIT_LAST) ? STOP : DATA;
      end
      STOP: if (samp_q == SAMP_END) begin
        // Framing is judged before parity so only one pulse can fire.
        if (rxs != STOP_BIT) begin
          ferr_d  = 1'b1;
          state_d = BREAK;
        end else if (!odd_parity_ok(PARITY_MAX_W'(shreg_q))) begin
          perr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          data_d  = shreg_q[WIDTH-2:0];
          flag_d  = 1'b1;
          state_d = IDLE;
        end
      end
      BREAK: state_d = (rxs == STOP_BIT) ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= IDLE;
      samp_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      flag_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rxs_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      flag_q     <= flag_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      rxs_prev_q <= rxs;
    end

  assign rx_data      = data_q;
  assign rx_data_flag = flag_q;
  assign parity_error = perr_q;
  assign frame_error  = ferr_q;
  assign rx_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed plus randomized frames against a frame-level model
module tb_uart_rx_deframer;
  localparam int W  = 64;
  localparam int OS = 4;
  localparam int FL = (W + 2) * OS;

  logic clk = 1'b0, reset_n = 1'b0, rx_in = 1'b1;
  logic [W-2:0] rx_data;
  logic rx_data_flag, parity_error, frame_error, rx_busy;

  uart_rx_deframer #(.WIDTH(W), .OVERSAMPLE(OS)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_in        (rx_in),
    .rx_data      (rx_data),
    .rx_data_flag (rx_data_flag),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int n_flag = 0, n_perr = 0, n_ferr = 0, n_multi = 0, busy_cyc = 0;
  int flag_cyc[$];
  logic [W-2:0] flag_dat[$];
  logic [W-2:0] exp_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_data_flag) begin
      n_flag++;
      flag_cyc.push_back(cyc);
      flag_dat.push_back(rx_data);
    end
    if (parity_error) n_perr++;
    if (frame_error) n_ferr++;
    if (int'(rx_data_flag) + int'(parity_error) + int'(frame_error) > 1) n_multi++;
    if (rx_busy) busy_cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-2:0] pl, input bit flip, input bit stop, input int nbits);
    logic [W+1:0] frm;
    frm = {stop, ~(^pl) ^ flip, pl, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx_in = frm[i];
      repeat (OS) @(negedge clk);
    end
    rx_in = 1'b1;
  endtask

  // Sends one frame and checks the outcome predicted from ones-count and stop bit.
  task automatic run_frame(input string tag, input logic [W-2:0] pl, input bit flip, input bit stop);
    int f0, p0, e0, outcome;
    f0 = n_flag; p0 = n_perr; e0 = n_ferr;
    send(pl, flip, stop, W + 2);
    if (!stop) begin
      rx_in = 1'b0;
      repeat (10 * OS) @(negedge clk);
      rx_in = 1'b1;
    end
    repeat (10) @(negedge clk);
    outcome = !stop ? 2 : ($countones({~(^pl) ^ flip, pl}) % 2 == 0) ? 1 : 0;
    if (outcome == 0) exp_data = pl;
    chk({tag, "_flag"}, 64'(n_flag - f0), 64'(outcome == 0));
    chk({tag, "_perr"}, 64'(n_perr - p0), 64'(outcome == 1));
    chk({tag, "_ferr"}, 64'(n_ferr - e0), 64'(outcome == 2));
    chk({tag, "_data"}, 64'(rx_data), 64'(exp_data));
    chk({tag, "_busy"}, 64'(rx_busy), 64'(0));
  endtask

  initial begin
    logic [W-2:0] pl1, pl2;
    int f0, p0, e0, b0, q0;
    #12;
    chk("rst_data", 64'(rx_data), 64'(0));
    chk("rst_pulses", 64'({rx_data_flag, parity_error, frame_error}), 64'(0));
    chk("rst_busy", 64'(rx_busy), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    run_frame("good", 63'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
    run_frame("parity", 63'h0123_4567_89AB_CDEF, 1'b1, 1'b1);
    run_frame("stop0", (W-1)'({$urandom(), $urandom()}), 1'b0, 1'b0);
    run_frame("after_break", (W-1)'({$urandom(), $urandom()}), 1'b0, 1'b1);

    f0 = n_flag; p0 = n_perr; e0 = n_ferr; b0 = busy_cyc;
    rx_in = 1'b0;
    repeat ((OS / 2 - 1 > 0) ? OS / 2 - 1 : 1) @(negedge clk);
    rx_in = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_busy", 64'(rx_busy), 64'(0));
    chk("glitch_pulses", 64'((n_flag - f0) + (n_perr - p0) + (n_ferr - e0)), 64'(0));
`ifdef UART_RX_GLITCH_FILTER_EN
    chk("glitch_busy_cycles", 64'(busy_cyc - b0), 64'(0));
`else
    chk("glitch_busy_short", 64'(busy_cyc - b0 <= OS), 64'(1));
`endif

    pl1 = (W-1)'({$urandom(), $urandom()});
    pl2 = (W-1)'({$urandom(), $urandom()});
    f0 = n_flag; q0 = flag_cyc.size();
    send(pl1, 1'b0, 1'b1, W + 2);
    send(pl2, 1'b0, 1'b1, W + 2);
    repeat (10) @(negedge clk);
    exp_data = pl2;
    chk("b2b_count", 64'(n_flag - f0), 64'(2));
    if (flag_cyc.size() >= q0 + 2) begin
      chk("b2b_gap", 64'(flag_cyc[q0 + 1] - flag_cyc[q0]), 64'(FL));
      chk("b2b_data1", 64'(flag_dat[q0]), 64'(pl1));
      chk("b2b_data2", 64'(flag_dat[q0 + 1]), 64'(pl2));
    end
    chk("b2b_hold", 64'(rx_data), 64'(exp_data));

    f0 = n_flag; p0 = n_perr; e0 = n_ferr;
    send((W-1)'({$urandom(), $urandom()}), 1'b0, 1'b1, 31);
    reset_n = 1'b0;
    rx_in = 1'b1;
    #1;
    exp_data = '0;
    chk("mid_rst_data", 64'(rx_data), 64'(exp_data));
    chk("mid_rst_busy", 64'(rx_busy), 64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_no_pulse", 64'((n_flag - f0) + (n_perr - p0) + (n_ferr - e0)), 64'(0));
    run_frame("post_rst", (W-1)'({$urandom(), $urandom()}), 1'b0, 1'b1);

    for (int i = 0; i < 12; i++)
      run_frame($sformatf("rand%0d", i), (W-1)'({$urandom(), $urandom()}),
                $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0);

    chk("one_hot_pulses", 64'(n_multi), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
